// File: rtl/wb_pkg.sv
// Shared write-buffer types: entry layout, drain states, byte-merge helper.
package wb_pkg;

    localparam int unsigned ENT_AW = 30;
    localparam int unsigned ENT_DW = 32;
    localparam int unsigned ENT_SW = ENT_DW / 8;

    typedef struct packed {
        logic [ENT_AW-1:0] addr;
        logic [ENT_DW-1:0] data;
        logic [ENT_SW-1:0] sel;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } drain_state_e;

    function automatic logic [ENT_DW-1:0] merge_bytes(
        input logic [ENT_DW-1:0] old_d,
        input logic [ENT_DW-1:0] new_d,
        input logic [ENT_SW-1:0] sel
    );
        logic [ENT_DW-1:0] r;
        r = old_d;
        for (int b = 0; b < int'(ENT_SW); b++) begin
            if (sel[b]) r[8*b +: 8] = new_d[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with exposed entries and an in-place update of the youngest slot.
module sync_fifo #(
    parameter int unsigned DW         = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 push_i,
    input  logic [DW-1:0]                        push_data_i,
    input  logic                                 pop_i,
    input  logic                                 upd_i,
    input  logic [DW-1:0]                        upd_data_i,
    output logic [DEPTH_LOG2:0]                  count_o,
    output logic [DEPTH_LOG2-1:0]                head_ptr_o,
    output logic [DEPTH_LOG2-1:0]                last_ptr_o,
    output logic [(1<<DEPTH_LOG2)-1:0]           valid_o,
    output logic [(1<<DEPTH_LOG2)-1:0][DW-1:0]   mem_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

    logic [DEPTH_LOG2-1:0]        head_q, head_d;
    logic [DEPTH_LOG2-1:0]        tail_q, tail_d;
    logic [DEPTH_LOG2:0]          count_q, count_d;
    logic [DEPTH-1:0][DW-1:0]     mem_q, mem_d;
    logic [DEPTH_LOG2-1:0]        last_idx;

    assign last_idx = tail_q - PTR_ONE;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (upd_i) mem_d[last_idx] = upd_data_i;
        if (push_i) begin
            mem_d[tail_q] = push_data_i;
            tail_d        = tail_q + PTR_ONE;
        end
        if (pop_i) head_d = head_q + PTR_ONE;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: validity comes from head/count alone.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        valid_o = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            valid_o[i] = {1'b0, DEPTH_LOG2'(i) - head_q} < count_q;
        end
    end

    assign count_o    = count_q;
    assign head_ptr_o = head_q;
    assign last_ptr_o = last_idx;
    assign mem_o      = mem_q;

endmodule

// File: rtl/write_buffer.sv
// Store write buffer: pending stores drained one at a time over pipelined wishbone.
// Define WRITE_BUFFER_MERGE_EN to coalesce same-address stores into the youngest entry.
module write_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned AW         = ENT_AW,
    parameter int unsigned DW         = ENT_DW,
    localparam int unsigned SW        = DW / 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic [SW-1:0] push_sel_i,
    input  logic [AW-1:0] query_addr_i,
    output logic          query_hit_o,
    output logic          empty_o,
    output logic          err_o,
    output logic          mem_cyc_o,
    output logic          mem_stb_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [SW-1:0] mem_sel_o,
    input  logic          mem_ack_i,
    input  logic          mem_err_i,
    input  logic          mem_stall_i
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned EW    = $bits(entry_t);
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE  = (DEPTH_LOG2 + 1)'(1);
`ifdef WRITE_BUFFER_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    drain_state_e             state_q, state_d;
    logic                     cyc_q, cyc_d;
    logic                     stb_q, stb_d;
    logic                     err_q, err_d;
    logic [DEPTH_LOG2:0]      count;
    logic [DEPTH_LOG2-1:0]    head_ptr, last_ptr;
    logic [DEPTH-1:0]         valid;
    logic [DEPTH-1:0][EW-1:0] mem;
    entry_t                   head, last, push_e, upd_e;
    logic                     in_flight, can_merge, merge, alloc, pop, hit;

    assign head = entry_t'(mem[head_ptr]);
    assign last = entry_t'(mem[last_ptr]);

    always_comb begin
        push_e.addr = push_addr_i;
        push_e.data = push_data_i;
        push_e.sel  = push_sel_i;
        upd_e.addr  = last.addr;
        upd_e.data  = merge_bytes(last.data, push_data_i, push_sel_i);
        upd_e.sel   = last.sel | push_sel_i;
    end

    // Youngest is in flight only when it is also the head being drained.
    assign in_flight = (state_q != IDLE) && (count == ONE);
    assign can_merge = MERGE && (count != '0) && !in_flight
                       && (last.addr == push_addr_i);
    assign push_ready_o = (count != FULL) || can_merge;
    assign merge = push_valid_i && can_merge;
    assign alloc = push_valid_i && (count != FULL) && !can_merge;
    assign pop   = (state_q == WAIT_ACK) && (mem_ack_i || mem_err_i);

    sync_fifo #(
        .DW         (EW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (alloc),
        .push_data_i (push_e),
        .pop_i       (pop),
        .upd_i       (merge),
        .upd_data_i  (upd_e),
        .count_o     (count),
        .head_ptr_o  (head_ptr),
        .last_ptr_o  (last_ptr),
        .valid_o     (valid),
        .mem_o       (mem)
    );

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid[i] && (mem[i][EW-1 -: AW] == query_addr_i)) hit = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    state_d = REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                end
            end
            REQ: begin
                if (!mem_stall_i) begin
                    state_d = WAIT_ACK;
                    stb_d   = 1'b0;
                end
            end
            WAIT_ACK: begin
                if (mem_ack_i || mem_err_i) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    err_d   = mem_err_i;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    assign mem_cyc_o   = cyc_q;
    assign mem_stb_o   = stb_q;
    assign mem_we_o    = cyc_q;
    assign mem_addr_o  = head.addr;
    assign mem_wdata_o = head.data;
    assign mem_sel_o   = head.sel;
    assign query_hit_o = hit;
    assign empty_o     = (count == '0) && (state_q == IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: queue-level store model checked every cycle plus directed cases.
module tb_write_buffer;

    localparam int DEPTH = 4;
`ifdef WRITE_BUFFER_MERGE_EN
    localparam bit MERGE_TB = 1'b1;
`else
    localparam bit MERGE_TB = 1'b0;
`endif

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } st_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        push_valid_i;
    logic        push_ready_o;
    logic [29:0] push_addr_i;
    logic [31:0] push_data_i;
    logic [3:0]  push_sel_i;
    logic [29:0] query_addr_i;
    logic        query_hit_o, empty_o, err_o;
    logic        mem_cyc_o, mem_stb_o, mem_we_o;
    logic [29:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_sel_o;
    logic        mem_ack_i = 1'b0;
    logic        mem_err_i = 1'b0;
    logic        mem_stall_i;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    st_t q[$];
    st_t wlog[$];
    bit  outstanding = 1'b0;
    bit  exp_err = 1'b0;

    int  ack_delay = 0;
    bit  err_once = 1'b0;
    int  pend = -1;

    always #5 clk = ~clk;

    write_buffer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_addr_i  (push_addr_i),
        .push_data_i  (push_data_i),
        .push_sel_i   (push_sel_i),
        .query_addr_i (query_addr_i),
        .query_hit_o  (query_hit_o),
        .empty_o      (empty_o),
        .err_o        (err_o),
        .mem_cyc_o    (mem_cyc_o),
        .mem_stb_o    (mem_stb_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_sel_o    (mem_sel_o),
        .mem_ack_i    (mem_ack_i),
        .mem_err_i    (mem_err_i),
        .mem_stall_i  (mem_stall_i)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        push_valid_i = 1'b1;
        push_addr_i  = a;
        push_data_i  = d;
        push_sel_i   = s;
        tick();
        push_valid_i = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (empty_o === 1'b1) done = 1'b1;
        end
        if (!done) timeout(name);
        tick();
    endtask

    // Wishbone slave: ack (or one-shot err) ack_delay cycles after strobe accept.
    always @(posedge clk) begin
        logic acc;
        acc = mem_stb_o & ~mem_stall_i;
        #1;
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
        if (acc === 1'b1) pend = ack_delay;
        else if (pend > 0) pend--;
        if (pend == 0) begin
            if (err_once) begin
                mem_err_i = 1'b1;
                err_once  = 1'b0;
            end else begin
                mem_ack_i = 1'b1;
            end
            pend = -1;
        end
    end

    // Store-level model: pending queue, in-order bus writes, pop on completion.
    always @(negedge clk) begin
        bit hit_e, full, can_m, popped;
        logic [31:0] mask;
        if (chk_en) begin
            hit_e = 1'b0;
            foreach (q[i]) if (q[i].a == query_addr_i) hit_e = 1'b1;
            full  = (q.size() == DEPTH);
            can_m = MERGE_TB && (q.size() != 0) && (q[$].a == push_addr_i)
                    && !((q.size() == 1) && mem_cyc_o);
            check("ready", push_ready_o, !full || can_m);
            check("empty", empty_o, q.size() == 0);
            check("hit", query_hit_o, hit_e);
            check("err", err_o, exp_err);
            check("cyc_without_entry", mem_cyc_o && (q.size() == 0), 1'b0);
            if (mem_stb_o) check("we_stb", {mem_we_o, mem_cyc_o}, 2'b11);
            if (mem_cyc_o && q.size() != 0) begin
                check("bus_addr", mem_addr_o, q[0].a);
                check("bus_data", mem_wdata_o, q[0].d);
                check("bus_sel", mem_sel_o, q[0].s);
            end
            exp_err = 1'b0;
            if (rst_i) begin
                q.delete();
                outstanding = 1'b0;
            end else begin
                popped = outstanding && (mem_ack_i || mem_err_i);
                if (push_valid_i) begin
                    if (can_m) begin
                        mask = '0;
                        for (int b = 0; b < 4; b++)
                            if (push_sel_i[b]) mask[8*b +: 8] = 8'hFF;
                        q[q.size()-1].d = (q[$].d & ~mask) | (push_data_i & mask);
                        q[q.size()-1].s = q[$].s | push_sel_i;
                    end else if (!full) begin
                        q.push_back('{push_addr_i, push_data_i, push_sel_i});
                    end
                end
                if (mem_stb_o && !mem_stall_i) begin
                    check("one_outstanding", outstanding, 1'b0);
                    wlog.push_back('{mem_addr_o, mem_wdata_o, mem_sel_o});
                    outstanding = 1'b1;
                end
                if (popped) begin
                    exp_err = mem_err_i;
                    void'(q.pop_front());
                    outstanding = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        rst_i = 1'b1;
        push_valid_i = 1'b0;
        push_addr_i = '0;
        push_data_i = '0;
        push_sel_i = '0;
        query_addr_i = '0;
        mem_stall_i = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_ready", push_ready_o, 1'b1);
        check("rst_empty", empty_o, 1'b1);
        check("rst_cyc_stb_we", {mem_cyc_o, mem_stb_o, mem_we_o}, 3'b000);
        check("rst_err", err_o, 1'b0);
        check("rst_hit", query_hit_o, 1'b0);
        tick();

        // Single store, zero-wait slave; stb two edges after the push edge.
        wlog.delete();
        push(30'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        check("lat_stb_edge1", mem_stb_o, 1'b0);
        @(negedge clk);
        check("lat_stb_edge2", mem_stb_o, 1'b1);
        wait_empty("t1_empty");
        check("t1_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) begin
            check("t1_addr", wlog[0].a, 30'h10);
            check("t1_data", wlog[0].d, 32'hDEADBEEF);
            check("t1_sel", wlog[0].s, 4'hF);
        end

        // Fill under stall, hold off a fifth push, then drain in order.
        wlog.delete();
        mem_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) push(30'h40 + 30'(i), 32'h1000 + i, 4'hF);
        @(negedge clk);
        check("t2_full_ready", push_ready_o, 1'b0);
        push_valid_i = 1'b1;
        push_addr_i = 30'h99;
        push_data_i = 32'h99;
        tick();
        tick();
        tick();
        push_valid_i = 1'b0;
        mem_stall_i = 1'b0;
        wait_empty("t2_empty");
        check("t2_nwrites", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            check("t2_order", wlog[i].a, 30'h40 + 30'(i));

        // Query hit held until the cycle after a 5-cycle-late ack.
        ack_delay = 5;
        query_addr_i = 30'h20;
        push(30'h20, 32'h2020, 4'hF);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (query_hit_o) n++;
        end
        check("t3_hit_cycles", n, 8);
        check("t3_hit_after", query_hit_o, 1'b0);
        tick();
        query_addr_i = 30'h24;
        push(30'h20, 32'h2121, 4'hF);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (query_hit_o) n++;
        end
        check("t3_miss_cycles", n, 0);
        tick();
        query_addr_i = '0;
        ack_delay = 0;

        // Error on the first of two stores: dropped, second still written.
        wlog.delete();
        err_once = 1'b1;
        push(30'h50, 32'h5050, 4'hF);
        push(30'h54, 32'h5454, 4'hF);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (err_o) n++;
        end
        check("t4_err_pulses", n, 1);
        check("t4_empty", empty_o, 1'b1);
        check("t4_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) check("t4_second", wlog[1].a, 30'h54);
        tick();

        // Same-address stores behind a stalled head.
        wlog.delete();
        mem_stall_i = 1'b1;
        push(30'h28, 32'h11111111, 4'hF);
        push(30'h30, 32'h0000AAAA, 4'h3);
        push(30'h30, 32'hBBBB0000, 4'hC);
        mem_stall_i = 1'b0;
        wait_empty("t5_empty");
        if (MERGE_TB) begin
            check("t5_nwrites", wlog.size(), 2);
            if (wlog.size() == 2) begin
                check("t5_merged_data", wlog[1].d, 32'hBBBBAAAA);
                check("t5_merged_sel", wlog[1].s, 4'hF);
            end
        end else begin
            check("t5_nwrites", wlog.size(), 3);
            if (wlog.size() == 3) begin
                check("t5_w1_data", wlog[1].d, 32'h0000AAAA);
                check("t5_w2_data", wlog[2].d, 32'hBBBB0000);
            end
        end

        // Reset during WAIT_ACK with three entries; the late ack is ignored.
        wlog.delete();
        ack_delay = 8;
        push(30'h60, 32'h60, 4'hF);
        push(30'h61, 32'h61, 4'hF);
        push(30'h62, 32'h62, 4'hF);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("t6_cyc", mem_cyc_o, 1'b0);
        check("t6_empty", empty_o, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        check("t6_late_empty", empty_o, 1'b1);
        check("t6_late_ready", push_ready_o, 1'b1);
        tick();
        ack_delay = 0;
        push(30'h70, 32'h7070, 4'h5);
        wait_empty("t6_recover");
        check("t6_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) check("t6_recover_addr", wlog[1].a, 30'h70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 2, log2 of the entry count (DEPTH = 2**DEPTH_LOG2).
REQ-002 Parameter AW, default 30, word-address width.
REQ-003 Parameter DW, default 32, data width; SW = DW/8 byte selects.
REQ-004 Ports, one per line:
- clk_i  in  1  the single clock.
- rst_i  in  1  reset; synchronous, active-high.
- push_valid_i  in  1  store request from the data cache.
- push_ready_o  out  1  buffer can accept a store.
- push_addr_i  in  AW  store word address.
- push_data_i  in  DW  store data.
- push_sel_i  in  SW  store byte enables.
- query_addr_i  in  AW  load address for the hazard check.
- query_hit_o  out  1  a pending store matches query_addr_i.
- empty_o  out  1  no entries held and none in flight.
- err_o  out  1  one-cycle pulse on mem_err_i.
- mem_cyc_o, mem_stb_o, mem_we_o  out  1 each  wishbone master cycle, strobe, write-enable.
- mem_addr_o  out  AW; mem_wdata_o  out  DW; mem_sel_o  out  SW.
- mem_ack_i, mem_err_i, mem_stall_i  in  1 each  wishbone slave responses (pipelined mode).

Function
REQ-005 Circular FIFO of DEPTH entries {addr, data, sel}, with head/tail pointers of DEPTH_LOG2 bits plus a count of DEPTH_LOG2+1 bits; pointers wrap modulo DEPTH.
REQ-006 push_ready_o = (count != DEPTH); a push occurs when push_valid_i & push_ready_o; push_valid_i while full is held off and nothing is written.
REQ-007 A pop in the same cycle does not free a slot for a same-cycle push (no full bypass); a simultaneous push and pop when not full leaves count unchanged.
REQ-008 Drain FSM states: IDLE, REQ, WAIT_ACK.
- IDLE: when count != 0, move to REQ.
- REQ: cyc=stb=we=1 with head addr/data/sel; when !mem_stall_i, move to WAIT_ACK.
- WAIT_ACK: cyc=1, stb=0; on mem_ack_i or mem_err_i, pop head and move to IDLE.
REQ-009 At most one wishbone transaction outstanding; mem_addr_o, mem_wdata_o and mem_sel_o are stable from the start of REQ until the ack.
REQ-010 mem_err_i is treated as completion: the entry is dropped and err_o pulses for 1 cycle; no retry.
REQ-011 query_hit_o is combinational: OR over all valid entries, including the in-flight head, of addr == query_addr_i; it deasserts the cycle after the matching ack pops the entry.
REQ-012 empty_o = (count == 0) & (state == IDLE).
REQ-013 Minimum push-to-stb latency is 2 cycles: push at N, IDLE->REQ at N+1, stb at N+1 registered out at N+1 edge, so stb is visible at N+2 in a registered view.

Reset
REQ-014 While rst_i is sampled high at a clock edge: pointers and count go to 0, FSM to IDLE, all entries invalid.
REQ-015 Reset values of outputs: mem_cyc_o=0, mem_stb_o=0, mem_we_o=0, push_ready_o=1, empty_o=1, err_o=0, query_hit_o=0.
REQ-016 Reset mid-transaction abandons the bus cycle (cyc drops in the next cycle), discards all entries, and ignores any later ack.

Configuration
REQ-017 Macro WRITE_BUFFER_MERGE_EN enables store coalescing.
- Defined: a push whose addr equals the youngest entry's addr, with that entry not in flight, merges into it. Bytes selected by push_sel_i overwrite that entry's data, sel becomes the OR of old and new, and count is unchanged. A merge is accepted even when the buffer is full.
- Undefined: every push allocates a new entry.

Structure
REQ-018 A shared package wb_pkg holds the entry struct typedef (addr, data, sel) and the drain-FSM state enum.
REQ-019 The storage and pointer logic is one sub-module, sync_fifo (parameters DW and DEPTH_LOG2), which also exposes its entries for the query compare; the FSM and merge logic stay in write_buffer.

Verification
REQ-020 Single push of addr 0x10, data 0xDEADBEEF, sel 0xF, with a zero-wait slave -> one wishbone write to 0x10 with that data; empty_o returns to 1 after the ack.
REQ-021 Push 4 stores with DEPTH=4 while mem_stall_i=1 -> push_ready_o=0 and a 5th push is held off. Then release the stall -> the writes go out in FIFO order 0,1,2,3.
REQ-022 Push addr 0x20 while the slave withholds ack for 5 cycles, with query_addr_i=0x20 -> query_hit_o=1 until the cycle after the ack, then 0. query_addr_i=0x24 -> query_hit_o=0 throughout.
REQ-023 mem_err_i on the first of 2 stores -> err_o pulses once, the second store is still written, and count ends at 0.
REQ-024 With WRITE_BUFFER_MERGE_EN, push 0x30/sel 0x3/data 0x0000AAAA, then 0x30/sel 0xC/data 0xBBBB0000 while stalled -> a single write with data 0xBBBBAAAA and sel 0xF. Without the macro -> 2 writes.
REQ-025 Assert rst_i for one cycle during WAIT_ACK with 3 entries held -> next cycle cyc=0, empty_o=1, and a late ack causes no pop.
